// File: rtl/tokenizer_pkg.sv
// Shared token codes, FSM states and character constants for the word tokenizer.
package tokenizer_pkg;

  localparam logic [1:0] TOK_NONE  = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;
  localparam logic [1:0] TOK_OTHER = 2'd3;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE,
    S_B,
    S_BE,
    S_BEG,
    S_BEGI,
    S_BEGIN,
    S_E,
    S_EN,
    S_END,
    S_OTH
  } state_e;

endpackage

// File: rtl/tok_fifo.sv
// DEPTH x 2-bit synchronous token FIFO; head is shown combinationally, TOK_NONE when empty.
module tok_fifo
  import tokenizer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [1:0]    wdata,
  input  logic          pop,
  output logic [1:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = empty ? TOK_NONE : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TOK_NONE;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/word_tokenizer.sv
// Splits an ASCII stream on spaces and queues one BEGIN/END/OTHER token per word.
// Build option: CASE_FOLD_EN folds 'A'..'Z' to lowercase before keyword matching.
module word_tokenizer
  import tokenizer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tok_valid,
  output logic [1:0] tok,
  input  logic       tok_ready,
  output logic       overflow
);

  state_e      state_q;
  logic        overflow_q;
  logic [7:0]  ch;
  logic        accept;
  logic        is_space;
  logic        push;
  logic [1:0]  push_tok;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

`ifdef CASE_FOLD_EN
  assign ch = (in >= 8'h41 && in <= 8'h5A) ? (in | 8'h20) : in;
`else
  assign ch = in;
`endif

  assign in_ready  = (fifo_count != (AW+1)'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign is_space  = (ch == CHAR_SPACE);
  assign push      = accept && is_space && (state_q != S_IDLE);
  assign push_tok  = (state_q == S_BEGIN) ? TOK_BEGIN :
                     (state_q == S_END)   ? TOK_END   : TOK_OTHER;
  assign tok_valid = !fifo_empty;
  assign overflow  = overflow_q;

  // Only a completed keyword followed by a space is special; anything else collapses to S_OTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      overflow_q <= 1'b0;
    end else begin
      if (push && fifo_full) overflow_q <= 1'b1;
      if (accept) begin
        if (is_space) begin
          state_q <= S_IDLE;
        end else begin
          case (state_q)
            S_IDLE:  state_q <= (ch == "b") ? S_B : (ch == "e") ? S_E : S_OTH;
            S_B:     state_q <= (ch == "e") ? S_BE    : S_OTH;
            S_BE:    state_q <= (ch == "g") ? S_BEG   : S_OTH;
            S_BEG:   state_q <= (ch == "i") ? S_BEGI  : S_OTH;
            S_BEGI:  state_q <= (ch == "n") ? S_BEGIN : S_OTH;
            S_E:     state_q <= (ch == "n") ? S_EN    : S_OTH;
            S_EN:    state_q <= (ch == "d") ? S_END   : S_OTH;
            default: state_q <= S_OTH;
          endcase
        end
      end
    end
  end

  tok_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata (push_tok),
    .pop   (tok_ready),
    .rdata (tok),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_word_tokenizer.sv
// Directed bench for word_tokenizer: vector table plus hand sequences for reset and push/pop overlap.
module tb_word_tokenizer;

  localparam logic [1:0] T_NONE  = 2'd0;
  localparam logic [1:0] T_BEGIN = 2'd1;
  localparam logic [1:0] T_END   = 2'd2;
  localparam logic [1:0] T_OTHER = 2'd3;

  typedef struct {
    logic [7:0] ch;
    logic       vld;
    logic       rdy;
    logic       etv;
    logic [1:0] etok;
    logic       eir;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_c;
  logic       in_valid;
  logic       in_ready;
  logic       tok_valid;
  logic [1:0] tok;
  logic       tok_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  word_tokenizer dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_c),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tok_valid (tok_valid),
    .tok       (tok),
    .tok_ready (tok_ready),
    .overflow  (overflow)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(logic [7:0] ch, logic vld, logic rdy, logic etv, logic [1:0] etok, logic eir);
    vec_t v;
    v.ch = ch; v.vld = vld; v.rdy = rdy; v.etv = etv; v.etok = etok; v.eir = eir;
    vecs.push_back(v);
  endtask

  // e: '-' = FIFO empty after the edge, B/E/O = that token at the head
  task automatic add_str(string s, string e);
    for (int i = 0; i < s.len(); i++) begin
      case (e[i])
        "B":     add(s[i], 1'b1, 1'b1, 1'b1, T_BEGIN, 1'b1);
        "E":     add(s[i], 1'b1, 1'b1, 1'b1, T_END,   1'b1);
        "O":     add(s[i], 1'b1, 1'b1, 1'b1, T_OTHER, 1'b1);
        default: add(s[i], 1'b1, 1'b1, 1'b0, T_NONE,  1'b1);
      endcase
    end
    add(8'h00, 1'b0, 1'b1, 1'b0, T_NONE, 1'b1);
  endtask

  task automatic feed(string s, logic rdy);
    for (int i = 0; i < s.len(); i++) begin
      in_c = s[i]; in_valid = 1'b1; tok_ready = rdy;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tok_ready = 1'b0;
  endtask

  task automatic check_out(string tag, logic etv, logic [1:0] etok, logic eir);
    check({tag, ".tok_valid"}, 32'(tok_valid), 32'(etv));
    check({tag, ".tok"},       32'(tok),       32'(etok));
    check({tag, ".in_ready"},  32'(in_ready),  32'(eir));
    check({tag, ".overflow"},  32'(overflow),  32'(1'b0));
  endtask

  initial begin
    reset = 1'b0; in_c = 8'h00; in_valid = 1'b0; tok_ready = 1'b0;

    // 1: keywords, each token visible for one cycle after its space
    add_str("begin end ", "-----B---E");
    // 2: case handling
`ifdef CASE_FOLD_EN
    add_str("bEgin EEnd ", "-----B----O");
`else
    add_str("bEgin EEnd ", "-----O----O");
`endif
    // 3: space runs and near-miss keywords
    add_str("   beg  endd x ", "------O-----O-O");
    // 4: fill with tok_ready low, stall, then drain
    add("a", 1, 0, 0, T_NONE,  1);
    add(" ", 1, 0, 1, T_OTHER, 1);
    add("b", 1, 0, 1, T_OTHER, 1);
    add(" ", 1, 0, 1, T_OTHER, 1);
    add("c", 1, 0, 1, T_OTHER, 1);
    add(" ", 1, 0, 1, T_OTHER, 1);
    add("d", 1, 0, 1, T_OTHER, 1);
    add(" ", 1, 0, 1, T_OTHER, 0);
    add("e", 1, 0, 1, T_OTHER, 0);
    add("e", 1, 0, 1, T_OTHER, 0);
    add("e", 1, 1, 1, T_OTHER, 1);
    add("e", 1, 1, 1, T_OTHER, 1);
    add(" ", 1, 1, 1, T_OTHER, 1);
    add(8'h00, 0, 1, 1, T_OTHER, 1);
    add(8'h00, 0, 1, 0, T_NONE,  1);

    #12;
    check_out("reset", 1'b0, T_NONE, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      in_c = vecs[i].ch; in_valid = vecs[i].vld; tok_ready = vecs[i].rdy;
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].etv, vecs[i].etok, vecs[i].eir);
    end
    in_valid = 1'b0; tok_ready = 1'b0;

    // 5: async reset mid-word with two tokens queued
    feed("begin end ", 1'b0);
    feed("begi", 1'b0);
    check_out("rst_pre", 1'b1, T_BEGIN, 1'b1);
    #2 reset = 1'b0;
    #1 check_out("rst_async", 1'b0, T_NONE, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    feed(" end ", 1'b0);
    check_out("rst_after", 1'b1, T_END, 1'b1);
    tok_ready = 1'b1;
    @(negedge clk);
    check_out("rst_single", 1'b0, T_NONE, 1'b1);
    tok_ready = 1'b0;

    // 6: simultaneous push and pop at count 2
    feed("begin end ", 1'b0);
    feed("x", 1'b0);
    check_out("pp_pre", 1'b1, T_BEGIN, 1'b1);
    in_c = " "; in_valid = 1'b1; tok_ready = 1'b1;
    @(negedge clk);
    check_out("pp_head1", 1'b1, T_END, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_out("pp_head2", 1'b1, T_OTHER, 1'b1);
    @(negedge clk);
    check_out("pp_empty", 1'b0, T_NONE, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
